// File: rtl/mdio_peripheral_pkg.sv
// Shared types and frame constants for the MDIO management-frame responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WTA,
        WDATA,
        RTA,
        RDATA,
        SKIP
    } mdio_state_e;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    // Bit index k at which each frame field ends.
    localparam logic [4:0] K_ST_END   = 5'd1;
    localparam logic [4:0] K_OP_END   = 5'd3;
    localparam logic [4:0] K_PHY_END  = 5'd8;
    localparam logic [4:0] K_REG_END  = 5'd13;
    localparam logic [4:0] K_TA_START = 5'd14;
    localparam logic [4:0] K_TA_END   = 5'd15;
    localparam logic [4:0] K_DATA_END = 5'd31;

endpackage

// File: rtl/mdio_peripheral_if.sv
// MDIO line and local register-file signals of the responder, grouped as one bundle.
interface mdio_peripheral_if;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic        MDIO_IN;
    logic        MDIO_DRIVE;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic [15:0] RD_DATA;

    modport slave (
        input  MDC, MDIO_OE, MDIO_OUT, RD_DATA,
        output MDIO_IN, MDIO_DRIVE, ADDR, WR_DATA, WR_STB, RD_STB
    );

    modport master (
        output MDC, MDIO_OE, MDIO_OUT, RD_DATA,
        input  MDIO_IN, MDIO_DRIVE, ADDR, WR_DATA, WR_STB, RD_STB
    );
endinterface

// File: rtl/mdio_peripheral_mdc_edge_detect.sv
// Detects MDC rising/falling edges against a one-CLK delayed copy of MDC.
module mdc_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic MDC,
    output logic rise,
    output logic fall
);
    logic mdc_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) mdc_q <= 1'b0;
        else        mdc_q <= MDC;
    end

    assign rise = MDC & ~mdc_q;
    assign fall = ~MDC & mdc_q;
endmodule

// File: rtl/mdio_peripheral.sv
// MDIO PHY-side responder: decodes controller frames into register-file writes/reads.
//
// state  | meaning
// IDLE   | preamble, waiting for the first ST bit (0)
// HEADER | ST[0], OP, PHYADR, REGADR (k = 1..13)
// WTA    | write turnaround, expects 1 then 0
// WDATA  | shifting in write data (k = 16..31)
// RTA    | read turnaround, takes the line at the k = 14 fall
// RDATA  | shifting out read data (k = 16..31)
// SKIP   | frame for another PHY or unknown opcode, count to k = 31
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input logic              CLK,
    input logic              RESET,
    mdio_peripheral_if.slave bus
);
    logic        rise, fall;
    mdio_state_e state_q;
    logic [4:0]  cnt_q;
    logic [11:0] hdr_q;
    logic [11:0] hdr_d;
    logic [15:0] wsh_q, rsh_q;
    logic [4:0]  addr_q;
    logic [15:0] wr_data_q;
    logic        wr_stb_q, rd_stb_q, rd_lat_q;
    logic        mdio_in_q, drive_q;

    mdc_edge_detect u_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .MDC   (bus.MDC),
        .rise  (rise),
        .fall  (fall)
    );

    // hdr_d = {OP[1:0], PHYADR[4:0], REGADR[4:0]} once the k = 13 bit is in.
    assign hdr_d = {hdr_q[10:0], bus.MDIO_OUT};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hdr_q     <= '0;
            wsh_q     <= '0;
            rsh_q     <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            rd_lat_q  <= 1'b0;
            mdio_in_q <= 1'b0;
            drive_q   <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            rd_stb_q <= 1'b0;
            rd_lat_q <= rd_stb_q;
            if (rd_lat_q) rsh_q <= bus.RD_DATA;

            unique case (state_q)
                IDLE: begin
                    if (rise && bus.MDIO_OE && (bus.MDIO_OUT == ST_CODE[1])) begin
                        state_q <= HEADER;
                        cnt_q   <= 5'd1;
                    end
                end
                HEADER: begin
                    if (rise) begin
                        if (!bus.MDIO_OE) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == K_ST_END) begin
                            if (bus.MDIO_OUT != ST_CODE[0]) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end else begin
                            hdr_q <= hdr_d;
                            cnt_q <= cnt_q + 5'd1;
                            if (cnt_q == K_REG_END) begin
                                if (hdr_d[9:5] == PHY_ADDR && hdr_d[11:10] == OP_WRITE) begin
                                    state_q <= WTA;
                                    addr_q  <= hdr_d[4:0];
                                end else if (hdr_d[9:5] == PHY_ADDR && hdr_d[11:10] == OP_READ) begin
                                    state_q  <= RTA;
                                    addr_q   <= hdr_d[4:0];
                                    rd_stb_q <= 1'b1;
                                end else begin
                                    state_q <= SKIP;
                                end
                            end
                        end
                    end
                end
                WTA: begin
                    if (rise) begin
                        if ((cnt_q == K_TA_START && bus.MDIO_OUT != TA_WRITE[1]) ||
                            (cnt_q == K_TA_END   && bus.MDIO_OUT != TA_WRITE[0])) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            if (cnt_q == K_TA_END) state_q <= WDATA;
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                WDATA: begin
                    if (rise) begin
                        if (!bus.MDIO_OE) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            wsh_q <= {wsh_q[14:0], bus.MDIO_OUT};
                            if (cnt_q == K_DATA_END) begin
                                wr_data_q <= {wsh_q[14:0], bus.MDIO_OUT};
                                wr_stb_q  <= 1'b1;
                                state_q   <= IDLE;
                                cnt_q     <= '0;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                end
                RTA: begin
                    // The fall seen while k = 15 is pending is the one ending k = 14.
                    if (fall && cnt_q == K_TA_END) begin
                        drive_q   <= 1'b1;
                        mdio_in_q <= 1'b0;
                    end else if (rise) begin
                        if (cnt_q == K_TA_END) state_q <= RDATA;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                RDATA: begin
                    if (fall) begin
                        mdio_in_q <= rsh_q[15];
                        rsh_q     <= {rsh_q[14:0], 1'b0};
                    end else if (rise) begin
                        if (bus.MDIO_OE || cnt_q == K_DATA_END) begin
                            drive_q   <= 1'b0;
                            mdio_in_q <= 1'b0;
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                SKIP: begin
                    if (rise) begin
                        if (cnt_q == K_DATA_END) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.MDIO_IN    = mdio_in_q;
    assign bus.MDIO_DRIVE = drive_q;
    assign bus.ADDR       = addr_q;
    assign bus.WR_DATA    = wr_data_q;
    assign bus.WR_STB     = wr_stb_q;
    assign bus.RD_STB     = rd_stb_q;
endmodule

// File: doc/mdio_peripheral.md
# mdio_peripheral

MDIO management-frame responder (PHY side) for the MDIO controller block in this codebase. It samples the serial frame the controller sends on MDC/MDIO and decodes the start, opcode, PHY-address and register-address fields. A write frame is turned into a single-cycle register-write strobe; a read frame fetches 16 bits from the local register file and shifts them back to the controller. It sits between the controller's MDC/MDIO_OUT/MDIO_OE outputs and a local 32x16 register file.

## Interface
- PHY_ADDR, 5'd0: this device's PHY address; frames with any other PHYADR are ignored.
- CLK  in  1  system clock; all logic runs on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MDC  in  1  management clock from the controller, synchronous to CLK, period ≥ 2 CLK periods.
- MDIO_OE  in  1  high while the controller drives MDIO_OUT.
- MDIO_OUT  in  1  serial data from the controller.
- MDIO_IN  out  1  serial data to the controller.
- MDIO_DRIVE  out  1  high while this block owns the data line.
- ADDR  out  5  register address of the current frame.
- WR_DATA  out  16  write data.
- WR_STB  out  1  one-CLK write strobe.
- RD_STB  out  1  one-CLK read request.
- RD_DATA  in  16  register-file read data, valid the CLK after RD_STB.

## Operation
- Frame format, bit index k = 0..31, MSB first within each field:
  - ST[1:0] = 01, k = 0–1.
  - OP[1:0], k = 2–3: 01 = write, 10 = read.
  - PHYADR[4:0], k = 4–8.
  - REGADR[4:0], k = 9–13.
  - TA[1:0], k = 14–15.
  - DATA[15:0], k = 16–31.
- Sampling:
  - A bit is sampled on each detected MDC rising edge (rise pulse).
  - In IDLE, HEADER and WDATA the sample counts only when MDIO_OE = 1. If MDIO_OE = 0 at a rise in HEADER or WDATA, the frame aborts to IDLE.
- The 5-bit bit counter holds k and increments on each counted rise.
- States:
  - IDLE: waits for a sampled 0 (preamble is ones, length not checked). Goes to HEADER with k = 1.
  - HEADER: the sample at k = 1 must be 1, otherwise go to IDLE. After k = 13 is sampled:
    - OP = 01 and PHYADR = PHY_ADDR: go to WTA.
    - OP = 10 and PHYADR = PHY_ADDR: go to RTA, load ADDR from REGADR, pulse RD_STB.
    - Otherwise: go to SKIP.
  - WTA: TA sampled at k = 14–15 must be 1 then 0, otherwise go to IDLE. ADDR loads from REGADR on entry. Then go to WDATA.
  - WDATA: shifts k = 16–31. After k = 31, loads WR_DATA, pulses WR_STB, goes to IDLE.
  - RTA: RD_DATA is latched into the output shifter the CLK after RD_STB. MDIO_OE is ignored in this state.
    - On the MDC fall that ends k = 14: MDIO_DRIVE = 1, MDIO_IN = 0.
    - After k = 15: go to RDATA.
  - RDATA: each MDC fall presents the next data bit, DATA[15] first. After the rise for k = 31: MDIO_DRIVE = 0, go to IDLE.
    - MDIO_OE = 1 at any rise in RDATA is a bus conflict: drop MDIO_DRIVE immediately and go to IDLE.
  - SKIP: counts rises through k = 31 regardless of MDIO_OE, never drives, then goes to IDLE.
- Reset values: all outputs 0; state IDLE; counter 0; shifters 0.
- RESET asserted mid-frame: outputs clear asynchronously, and any partially received write produces no WR_STB.

## Timing
- MDC edges are detected from a one-CLK registered copy of MDC. rise = MDC & ~mdc_q; fall = ~MDC & mdc_q. Each edge is detected 1 CLK after the MDC transition.
- WR_STB is high for exactly 1 CLK, the CLK after the rise that samples k = 31. WR_DATA and ADDR are valid on that cycle and hold until the next accepted frame.
- RD_STB is high for exactly 1 CLK, the CLK after the rise that samples k = 13. RD_DATA is captured the following CLK, which is well before the k = 14 MDC fall at the minimum MDC period.
- MDIO_IN changes only on the CLK after a fall pulse, giving a half MDC period of setup before the controller samples on the rise.
- Back-to-back frames: state is IDLE in the CLK after the k = 31 rise, so a ST bit in the very next MDC period is accepted.
- Counter wrap: 31 → 0 coincides with the return to IDLE; no other wrap occurs.

## Structure
- Package mdio_pkg:
  - State enum: IDLE, HEADER, WTA, WDATA, RTA, RDATA, SKIP.
  - Constants: ST_CODE = 2'b01, OP_WRITE = 2'b01, OP_READ = 2'b10, TA_WRITE = 2'b10.
  - Field-end indices: 1, 3, 8, 13, 15, 31.
- One sub-module, mdc_edge_detect: inputs CLK, RESET, MDC; outputs rise and fall pulses. Everything else is a single FSM with its shifters.

## Test plan
- Write frame: preamble of 32 ones, then 01 01 00000 00011 10 0xBEEF, PHY_ADDR = 0 → one WR_STB pulse, ADDR = 3, WR_DATA = 16'hBEEF, MDIO_DRIVE stays 0.
- Read frame: 01 10 00000 00101 with RD_DATA = 16'hA5C3 → one RD_STB with ADDR = 5. MDIO_DRIVE is high from the k = 14 fall to the k = 31 rise. The controller samples 0 at k = 15, then 1010010111000011.
- PHYADR = 00001 on a write → SKIP; no WR_STB, no drive; the next valid frame decodes normally.
- Write with TA = 11 → return to IDLE at k = 15; no WR_STB.
- RESET pulsed low at k = 20 of a read → MDIO_DRIVE and MDIO_IN are 0 within the same CLK. After release, a new write frame decodes correctly.
- Two back-to-back writes with no preamble between them (0x0001 to reg 1, 0xFFFF to reg 31) → two WR_STB pulses 32 MDC periods apart with matching ADDR and WR_DATA.
